i2c_target_rx: RTL and testbench



---
 rtl/i2c_target_pkg.sv | 29 ++
 rtl/i2c_line_sync.sv | 82 ++++++++
 rtl/i2c_target_rx.sv | 160 ++++++++++++++++
 tb/tb_i2c_target_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// ---------------------------------------------------------------------------
// i2c_target_pkg
// Shared types and constants for the I2C write-only target receiver.
//   state_t        : receiver FSM states
//   BITS_PER_BYTE  : bits shifted per byte before the ACK slot
//   DATA_BYTES     : data bytes that make up one committed word
//   addr_hit()     : true when an address byte selects this target for write
// ---------------------------------------------------------------------------
package i2c_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  localparam int BITS_PER_BYTE = 8;
  localparam int DATA_BYTES    = 2;

  // Write request to our address: upper seven bits match, R/W bit is 0.
  function automatic logic addr_hit(input logic [7:0] addr_byte,
                                    input logic [6:0] dev_addr);
    return (addr_byte[7:1] == dev_addr) && !addr_byte[0];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Brings one asynchronous I2C line into the CLOCK domain: two-flop
// synchronizer, optional 3-sample glitch filter, and rise/fall strobes.
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (adds the filter,
// +2 cycles of latency, rejects pulses of 2 cycles or less).
// Ports:
//   CLOCK, RESET : system clock, synchronous active-high reset
//   line_raw     : asynchronous bus line
//   level        : conditioned line level
//   rise, fall   : one-cycle strobes on conditioned level changes
// ---------------------------------------------------------------------------
module i2c_line_sync (
  input  logic CLOCK,
  input  logic RESET,
  input  logic line_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic [2:0] warm_cnt_q;
  logic       warm;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int WARM_CYCLES = 6;

  logic [1:0] hist_q;   // [0] = previous synchronized sample, [1] = one before
  logic       filt_q;
  logic       filt;

  // NOTE: every output of an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    filt = filt_q;
    if ((sync_q[1] == hist_q[0]) && (hist_q[0] == hist_q[1]))
      filt = sync_q[1];
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      filt_q <= filt;
    end
  end

  assign level = filt;
`else
  localparam int WARM_CYCLES = 4;

  assign level = sync_q[1];
`endif

  // Edges stay masked until the pipeline has refilled after reset, so a
  // line that happens to be low when reset drops never looks like an edge.
  assign warm = (warm_cnt_q == 3'(WARM_CYCLES));
  assign rise = warm &  level & ~prev_q;
  assign fall = warm & ~level &  prev_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      // NOTE: the flops reset to the idle-high bus level; there is no memory
      // array here that would need (or avoid) a reset.
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
      warm_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], line_raw};
      prev_q <= level;
      if (!warm)
        warm_cnt_q <= warm_cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/i2c_target_rx.sv
// ---------------------------------------------------------------------------
// i2c_target_rx
// Write-only I2C target: receives address + two data bytes, ACKs them by
// pulling SDA low, and commits {byte1, byte2} as one 16-bit word.
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (see i2c_line_sync).
// Ports:
//   CLOCK     : system clock (>= 8x SCL)
//   RESET     : synchronous active-high reset
//   I2C_SCLK  : bus clock, input only
//   I2C_SDAT  : open-drain data, driven 0 only in ACK slots
//   RX_DATA   : last committed word, holds until the next commit
//   RX_VALID  : one-cycle strobe when RX_DATA updates
//   BUSY      : high from address match until STOP/START/abort
//   ERR       : one-cycle strobe on a protocol error
// ---------------------------------------------------------------------------
module i2c_target_rx
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        I2C_SCLK,
  inout  wire         I2C_SDAT,
  output logic [15:0] RX_DATA,
  output logic        RX_VALID,
  output logic        BUSY,
  output logic        ERR
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .line_raw (I2C_SCLK),
    .level    (scl),
    .rise     (scl_rise),
    .fall     (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .line_raw (I2C_SDAT),
    .level    (sda),
    .rise     (sda_rise),
    .fall     (sda_fall)
  );

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [1:0] byte_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] byte1_q;
  logic       sda_drive_q;

  logic       start_det;
  logic       stop_det;
  logic       last_bit;
  logic [7:0] next_byte;

  assign start_det = scl & sda_fall;
  assign stop_det  = scl & sda_rise;
  assign last_bit  = scl_rise && (bit_cnt_q == 3'(BITS_PER_BYTE - 1));
  assign next_byte = {shift_q, sda};

  assign I2C_SDAT = sda_drive_q ? 1'b0 : 1'bz;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      byte1_q     <= '0;
      sda_drive_q <= 1'b0;
      RX_DATA     <= '0;
      RX_VALID    <= 1'b0;
      BUSY        <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      RX_VALID <= 1'b0;
      ERR      <= 1'b0;

      if (start_det || stop_det) begin
        // Bus conditions override everything, including an ACK in progress.
        // A repeated START only flags a half-received word; a STOP flags any
        // matched frame that has not committed.
        if (start_det)
          ERR <= BUSY && (byte_cnt_q == 2'd1);
        else
          ERR <= BUSY && (byte_cnt_q != 2'(DATA_BYTES));
        state_q     <= start_det ? ADDR : IDLE;
        bit_cnt_q   <= '0;
        byte_cnt_q  <= '0;
        BUSY        <= 1'b0;
        sda_drive_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise) begin
              shift_q   <= next_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (last_bit) begin
              if (addr_hit(next_byte, DEV_ADDR)) begin
                state_q <= ADDR_ACK;
                BUSY    <= 1'b1;
              end else begin
                state_q <= IGNORE;
              end
            end
          end

          // First SCL fall after the 8th bit starts the ACK, the next one ends
          // it, so SDA is held low across the whole 9th clock high phase.
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              if (!sda_drive_q) begin
                sda_drive_q <= 1'b1;
              end else begin
                sda_drive_q <= 1'b0;
                state_q     <= DATA;
              end
            end
          end

          DATA: begin
            if (scl_rise) begin
              shift_q   <= next_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (last_bit) begin
              if (byte_cnt_q == 2'd0) begin
                byte1_q    <= next_byte;
                byte_cnt_q <= 2'd1;
                state_q    <= DATA_ACK;
              end else if (byte_cnt_q == 2'(DATA_BYTES - 1)) begin
                RX_DATA    <= {byte1_q, next_byte};
                RX_VALID   <= 1'b1;
                byte_cnt_q <= 2'(DATA_BYTES);
                state_q    <= DATA_ACK;
              end else begin
                // Surplus byte: left un-ACKed and the frame is abandoned.
                ERR     <= 1'b1;
                BUSY    <= 1'b0;
                state_q <= IGNORE;
              end
            end
          end

          default: ;  // IDLE and IGNORE wait for a START or STOP
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_rx
// Self-checking bench for i2c_target_rx: a bit-banged bus master at
// SCL = CLOCK/16, a table of whole frames with expected ACKs, strobe counts
// and committed word, plus hand-written reset, repeated-START and glitch
// sequences.
// ---------------------------------------------------------------------------
module tb_i2c_target_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        m_sda;           // master SDA: 1 = released, 0 = pull low
  wire         sda_bus;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int vcnt     = 0;             // cycles with RX_VALID high
  int ecnt     = 0;             // cycles with ERR high
  int both_cnt = 0;             // cycles with both high

  always #5 clk = ~clk;

  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (sda_bus);

  i2c_target_rx #(.DEV_ADDR(7'h1A)) dut (
    .CLOCK    (clk),
    .RESET    (rst),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda_bus),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .BUSY     (busy),
    .ERR      (err)
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1) vcnt <= vcnt + 1;
    if (err === 1'b1) ecnt <= ecnt + 1;
    if (rx_valid === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
  end

  typedef struct {
    string       name;
    logic [31:0] bytes;         // first byte on the bus in [31:24]
    int          nbytes;
    logic [3:0]  exp_ack;       // bit i = byte i was ACKed
    int          exp_valid;     // RX_VALID cycles during the frame
    int          exp_err;       // ERR cycles during the frame
    logic [15:0] exp_data;      // RX_DATA after STOP
    logic        exp_busy;      // BUSY after the last byte, before STOP
  } frame_t;

  frame_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each bit: SCL low 8 cycles (SDA changes mid-low), SCL high 8 cycles.
  task automatic send_bit(input logic b);
    wait_cyc(4); m_sda = b;
    wait_cyc(4); scl = 1'b1;
    wait_cyc(8); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_cyc(4); m_sda = 1'b1;
    wait_cyc(4); scl = 1'b1;
    wait_cyc(4); ack = (sda_bus === 1'b0);
    wait_cyc(4); scl = 1'b0;
  endtask

  task automatic do_start();
    wait_cyc(4); m_sda = 1'b1;
    wait_cyc(4); scl = 1'b1;
    wait_cyc(4); m_sda = 1'b0;
    wait_cyc(4); scl = 1'b0;
  endtask

  task automatic do_stop();
    wait_cyc(4); m_sda = 1'b0;
    wait_cyc(4); scl = 1'b1;
    wait_cyc(4); m_sda = 1'b1;
    wait_cyc(8);
  endtask

  task automatic run_frame(input frame_t f);
    int         v0;
    int         e0;
    logic [3:0] acks;
    logic       a;
    v0   = vcnt;
    e0   = ecnt;
    acks = '0;
    do_start();
    for (int i = 0; i < f.nbytes; i++) begin
      send_byte(f.bytes[31 - 8*i -: 8], a);
      acks[i] = a;
    end
    check({f.name, "_busy_pre_stop"}, 32'(busy), 32'(f.exp_busy));
    do_stop();
    wait_cyc(8);
    check({f.name, "_acks"},  32'(acks), 32'(f.exp_ack));
    check({f.name, "_valid"}, vcnt - v0, f.exp_valid);
    check({f.name, "_err"},   ecnt - e0, f.exp_err);
    check({f.name, "_data"},  32'(rx_data), 32'(f.exp_data));
    check({f.name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    frame_t f;
    logic   a;
    int     v0;
    int     e0;
    int     exp_glitch_err;
    int     exp_glitch_busy;

    tbl[0] = '{"full_0c5a",  32'h340C5A00, 3, 4'b0111, 1, 0, 16'h0C5A, 1'b1};
    tbl[1] = '{"bad_addr",   32'h36000000, 1, 4'b0000, 0, 0, 16'h0C5A, 1'b0};
    tbl[2] = '{"full_1234",  32'h34123400, 3, 4'b0111, 1, 0, 16'h1234, 1'b1};
    tbl[3] = '{"read_req",   32'h35550000, 2, 4'b0000, 0, 0, 16'h1234, 1'b0};
    tbl[4] = '{"short_stop", 32'h34AB0000, 2, 4'b0011, 0, 1, 16'h1234, 1'b1};
    tbl[5] = '{"extra_byte", 32'h34010203, 4, 4'b0111, 1, 1, 16'h0102, 1'b0};

    rst   = 1'b1;
    scl   = 1'b1;
    m_sda = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(10);

    check("reset_rx_data",  32'(rx_data),  32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_busy",     32'(busy),     32'h0);
    check("reset_err",      32'(err),      32'h0);
    check("reset_sda",      32'(sda_bus),  32'h1);

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // Reset pulse while byte 1 is half shifted in.
    do_start();
    send_byte(8'h34, a);
    check("midrst_addr_ack", 32'(a), 32'h1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    v0 = vcnt;
    e0 = ecnt;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_rx_data", 32'(rx_data), 32'h0);
    check("midrst_busy",    32'(busy),    32'h0);
    check("midrst_sda",     32'(sda_bus), 32'h1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    wait_cyc(4);
    check("midrst_ignored_valid", vcnt - v0, 0);
    check("midrst_ignored_err",   ecnt - e0, 0);
    check("midrst_ignored_busy",  32'(busy), 32'h0);
    f = '{"after_reset", 32'h34FF0000, 3, 4'b0111, 1, 0, 16'hFF00, 1'b1};
    run_frame(f);

    // Repeated START after one data byte: ERR counted inside the new frame.
    do_start();
    send_byte(8'h34, a);
    check("rstart_addr_ack",  32'(a), 32'h1);
    send_byte(8'h11, a);
    check("rstart_byte1_ack", 32'(a), 32'h1);
    f = '{"rstart", 32'h34223300, 3, 4'b0111, 1, 1, 16'h2233, 1'b1};
    run_frame(f);

    // One-cycle SDA high glitch while SCL is high and SDA is low.
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    exp_glitch_err  = 0;
    exp_glitch_busy = 1;
`else
    exp_glitch_err  = 1;
    exp_glitch_busy = 0;
`endif
    do_start();
    send_byte(8'h34, a);
    check("glitch_addr_ack", 32'(a), 32'h1);
    e0 = ecnt;
    v0 = vcnt;
    wait_cyc(4); m_sda = 1'b0;
    wait_cyc(4); scl = 1'b1;
    wait_cyc(4); m_sda = 1'b1;
    wait_cyc(1); m_sda = 1'b0;
    wait_cyc(10);
    check("glitch_err",  ecnt - e0, exp_glitch_err);
    check("glitch_busy", 32'(busy), 32'(exp_glitch_busy));
    scl = 1'b0;
    do_stop();
    wait_cyc(8);
    check("glitch_total_err", ecnt - e0, 1);
    check("glitch_valid",     vcnt - v0, 0);
    check("glitch_data_held", 32'(rx_data), 32'h2233);
    check("glitch_busy_idle", 32'(busy), 32'h0);

    check("err_valid_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
